// File: rtl/and_unit_arbiter.sv
// -----------------------------------------------------------------------------
// and_unit_arbiter
//   Round-robin arbiter and sequencer sharing one registered bitwise-AND unit
//   among NUM_REQ requesters. A request is granted in IDLE, evaluated in EXEC
//   (one cycle), and held in RESP until the consumer accepts the result.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]        per-requester request valid
//   req_ready  out  [NUM_REQ]        one-hot (or zero) grant, combinational
//   req_a      in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NUM_REQ*WIDTH]  operand B, same packing
//   resp_valid out                   result valid
//   resp_ready in                    consumer accepts result
//   resp_y     out  [WIDTH]          A & B of the granted request
//   resp_id    out  [ID_W]           requester that produced resp_y
//   busy       out                   high whenever the sequencer is not idle
//   op_count   out  [16]             completed responses, wrapping
// -----------------------------------------------------------------------------
module and_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_y,
    output logic [ID_W-1:0]            resp_id,
    output logic                       busy,
    output logic [15:0]                op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;

    logic              found;
    logic [ID_W-1:0]   winner;

    // Winner search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [ID_W:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[ID_W-1:0];
            end
        end
    end

    // Grant is only offered while idle and out of reset, so it is one-hot or zero.
    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_y     <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // found implies req_valid[winner] & req_ready[winner].
                    if (found) begin
                        op_a   <= req_a[winner*WIDTH +: WIDTH];
                        op_b   <= req_b[winner*WIDTH +: WIDTH];
                        id_q   <= winner;
                        rr_ptr <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_y     <= op_a & op_b;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
